// File: rtl/goldschmidt_seq_if.sv
// Handshake and datapath bundle between the FP divide front end, the
// Goldschmidt sequencer and the mantissa-divider datapath.
interface goldschmidt_seq_if #(
  parameter int WIDTH = 23
);
  logic             start;
  logic             ready;
  logic             abort;
  logic [WIDTH-1:0] m1_in;
  logic [WIDTH-1:0] m2_in;
  logic [WIDTH-1:0] m1_q;
  logic [WIDTH-1:0] m2_q;
  logic             mode;
  logic             stage;
  logic             rem;
  logic [WIDTH-1:0] div_m3;
  logic [WIDTH-1:0] div_r;
  logic             div_dec;
  logic             valid;
  logic             res_ready;
  logic [WIDTH-1:0] m3;
  logic [WIDTH-1:0] r;
  logic             decrement_exponent;

  // Environment side: front end, divider datapath and result consumer
  modport master (
    output start, abort, m1_in, m2_in, div_m3, div_r, div_dec, res_ready,
    input  ready, m1_q, m2_q, mode, stage, rem, valid, m3, r, decrement_exponent
  );

  // Sequencer side
  modport slave (
    input  start, abort, m1_in, m2_in, div_m3, div_r, div_dec, res_ready,
    output ready, m1_q, m2_q, mode, stage, rem, valid, m3, r, decrement_exponent
  );
endinterface

// File: rtl/goldschmidt_seq.sv
// Goldschmidt mantissa-divider sequencer. Accepts one divide at a time,
// steps the divider through LOAD, ITERS x (MUL, CORR) and REM, then holds
// the captured quotient/remainder until the consumer takes it.
module goldschmidt_seq #(
  parameter int WIDTH = 23,
  parameter int ITERS = 4
) (
  input logic              clk,
  input logic              reset,
  goldschmidt_seq_if.slave bus
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_CORR,
    S_REM,
    S_HOLD
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           accept;
  logic           capture;

  // A divide is taken only from IDLE, and abort on the same edge vetoes it
  assign accept  = (state_q == S_IDLE) && bus.start && !bus.abort;
  // The result is sampled while leaving REM unless that edge is being flushed
  assign capture = (state_q == S_REM) && !bus.abort;

  // State and iteration counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; count holds completed iterations, bumped leaving CORR
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_MUL;
      S_MUL:  state_d = S_CORR;
      S_CORR: begin
        count_d = count_q + CW'(1);
        state_d = (count_d < ITERS_C) ? S_MUL : S_REM;
      end
      S_REM:  state_d = S_HOLD;
      S_HOLD: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    if (bus.abort) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // Moore decode of divider controls and handshake flags from the state
  always_comb begin
    bus.mode  = 1'b0;
    bus.stage = 1'b0;
    bus.rem   = 1'b0;
    bus.ready = 1'b0;
    bus.valid = 1'b0;
    case (state_q)
      S_IDLE: bus.ready = 1'b1;
      S_LOAD: bus.stage = 1'b1;
      S_MUL:  bus.mode  = 1'b1;
      S_CORR: begin
        bus.mode  = 1'b1;
        bus.stage = 1'b1;
      end
      S_REM: begin
        bus.mode = 1'b1;
        bus.rem  = 1'b1;
      end
      S_HOLD: bus.valid = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Operand latch on accept; values persist across abort and idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.m1_q <= '0;
      bus.m2_q <= '0;
    end else if (accept) begin
      bus.m1_q <= bus.m1_in;
      bus.m2_q <= bus.m2_in;
    end
  end

  // Result capture on the REM exit edge; held until the next capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.m3                 <= '0;
      bus.r                  <= '0;
      bus.decrement_exponent <= 1'b0;
    end else if (capture) begin
      bus.m3                 <= bus.div_m3;
      bus.r                  <= bus.div_r;
      bus.decrement_exponent <= bus.div_dec;
    end
  end

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Self-checking bench for goldschmidt_seq: one instance with four
// iterations for the main scenarios and one with a single iteration for
// back-to-back throughput.
module tb_goldschmidt_seq;

  localparam int W  = 23;
  localparam int I4 = 4;
  localparam int I1 = 1;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_LOAD = 3'b010;
  localparam logic [2:0] C_MUL  = 3'b100;
  localparam logic [2:0] C_CORR = 3'b110;
  localparam logic [2:0] C_REM  = 3'b101;

  logic clk;
  logic reset;

  int total;
  int bad;

  logic [W-1:0] last_m1;
  logic [W-1:0] last_m2;
  logic [W-1:0] last_m3;
  logic [W-1:0] last_r;
  logic         last_dec;

  goldschmidt_seq_if #(.WIDTH(W)) if4 ();
  goldschmidt_seq_if #(.WIDTH(W)) if1 ();

  goldschmidt_seq #(.WIDTH(W), .ITERS(I4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  goldschmidt_seq #(.WIDTH(W), .ITERS(I1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control sequence from accept to the last pre-HOLD cycle
  function automatic void build_trace(input int iters, output logic [2:0] tr[$]);
    tr = {};
    tr.push_back(C_LOAD);
    for (int i = 0; i < iters; i++) begin
      tr.push_back(C_MUL);
      tr.push_back(C_CORR);
    end
    tr.push_back(C_REM);
  endfunction

  task automatic randomize_div4();
    if4.div_m3  = W'($urandom);
    if4.div_r   = W'($urandom);
    if4.div_dec = 1'($urandom);
  endtask

  // Full divide on the four-iteration instance, with a start pulse during HOLD
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit fixed, input logic [W-1:0] fm3,
                                input logic fdec, input int hold_wait);
    logic [2:0]   tr[$];
    logic [W-1:0] e_m3;
    logic [W-1:0] e_r;
    logic         e_dec;
    e_m3 = '0;
    e_r = '0;
    e_dec = 1'b0;
    build_trace(I4, tr);
    check_output("idle_ready", 32'(if4.ready), 32'd1);
    if4.m1_in = a;
    if4.m2_in = b;
    if4.start = 1'b1;
    randomize_div4();
    @(negedge clk);
    if4.start = 1'b0;
    check_output("m1_latch", 32'(if4.m1_q), 32'(a));
    check_output("m2_latch", 32'(if4.m2_q), 32'(b));
    for (int k = 0; k < tr.size(); k++) begin
      if (k > 0) @(negedge clk);
      check_output($sformatf("ctrl_%0d", k), 32'({if4.mode, if4.stage, if4.rem}), 32'(tr[k]));
      check_output($sformatf("busy_valid_%0d", k), 32'(if4.valid), 32'd0);
      check_output($sformatf("busy_ready_%0d", k), 32'(if4.ready), 32'd0);
      randomize_div4();
      if (tr[k] == C_REM) begin
        if (fixed) begin
          if4.div_m3  = fm3;
          if4.div_dec = fdec;
        end
        e_m3  = if4.div_m3;
        e_r   = if4.div_r;
        e_dec = if4.div_dec;
      end
    end
    @(negedge clk);
    check_output("valid_at_latency", 32'(if4.valid), 32'd1);
    check_output("hold_ctrl", 32'({if4.mode, if4.stage, if4.rem}), 32'(C_IDLE));
    check_output("m3_capture", 32'(if4.m3), 32'(e_m3));
    check_output("r_capture", 32'(if4.r), 32'(e_r));
    check_output("dec_capture", 32'(if4.decrement_exponent), 32'(e_dec));
    for (int h = 0; h < hold_wait; h++) begin
      randomize_div4();
      if4.start = (h == 0);
      if4.m1_in = (h == 0) ? ~a : a;
      @(negedge clk);
      check_output("hold_valid", 32'(if4.valid), 32'd1);
      check_output("hold_ready", 32'(if4.ready), 32'd0);
      check_output("hold_m3", 32'(if4.m3), 32'(e_m3));
      check_output("hold_m1", 32'(if4.m1_q), 32'(a));
    end
    if4.start = 1'b0;
    if4.m1_in = a;
    if4.res_ready = 1'b1;
    @(negedge clk);
    if4.res_ready = 1'b0;
    check_output("release_ready", 32'(if4.ready), 32'd1);
    check_output("release_valid", 32'(if4.valid), 32'd0);
    @(negedge clk);
    check_output("no_queue_ready", 32'(if4.ready), 32'd1);
    check_output("no_queue_m1", 32'(if4.m1_q), 32'(a));
    last_m1  = a;
    last_m2  = b;
    last_m3  = e_m3;
    last_r   = e_r;
    last_dec = e_dec;
  endtask

  // Start an op and advance to the given trace index (checked), without finishing
  task automatic start_partial(input logic [W-1:0] a, input logic [W-1:0] b, input int upto);
    logic [2:0] tr[$];
    build_trace(I4, tr);
    if4.m1_in = a;
    if4.m2_in = b;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    for (int k = 0; k <= upto; k++) begin
      if (k > 0) @(negedge clk);
      randomize_div4();
      check_output($sformatf("partial_ctrl_%0d", k), 32'({if4.mode, if4.stage, if4.rem}), 32'(tr[k]));
    end
  endtask

  initial begin
    logic [2:0]   tr1[$];
    logic [W-1:0] e1_m3;
    logic [W-1:0] e1_m1;
    int           ph;

    total = 0;
    bad = 0;
    last_m1 = '0;
    last_m2 = '0;
    last_m3 = '0;
    last_r = '0;
    last_dec = 1'b0;
    e1_m3 = '0;
    reset = 1'b0;
    if4.start = 1'b0; if4.abort = 1'b0; if4.res_ready = 1'b0;
    if4.m1_in = '0; if4.m2_in = '0; if4.div_m3 = '0; if4.div_r = '0; if4.div_dec = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.res_ready = 1'b0;
    if1.m1_in = '0; if1.m2_in = '0; if1.div_m3 = '0; if1.div_r = '0; if1.div_dec = 1'b0;

    $display("[TB] reset state");
    #2;
    check_output("rst_ready", 32'(if4.ready), 32'd1);
    check_output("rst_valid", 32'(if4.valid), 32'd0);
    check_output("rst_ctrl", 32'({if4.mode, if4.stage, if4.rem}), 32'(C_IDLE));
    check_output("rst_m1", 32'(if4.m1_q), 32'd0);
    check_output("rst_m3", 32'(if4.m3), 32'd0);
    check_output("rst_dec", 32'(if4.decrement_exponent), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] zero operands with stubbed quotient");
    apply_stimulus('0, '0, 1'b1, 23'h2AAAAA, 1'b1, 5);
    check_output("t2_m3", 32'(last_m3), 32'h2AAAAA);
    check_output("t2_dec", 32'(last_dec), 32'd1);

    $display("[TB] random operands");
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(W'($urandom), W'($urandom), 1'b0, '0, 1'b0, 1 + int'($urandom_range(0, 3)));
    end

    $display("[TB] abort in second MUL");
    start_partial(W'($urandom), W'($urandom), 3);
    if4.abort = 1'b1;
    @(negedge clk);
    if4.abort = 1'b0;
    check_output("abort_ready", 32'(if4.ready), 32'd1);
    check_output("abort_ctrl", 32'({if4.mode, if4.stage, if4.rem}), 32'(C_IDLE));
    check_output("abort_m3", 32'(if4.m3), 32'(last_m3));
    check_output("abort_r", 32'(if4.r), 32'(last_r));
    last_m1 = if4.m1_in;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_output("abort_no_valid", 32'(if4.valid), 32'd0);
    end
    check_output("abort_m1_kept", 32'(if4.m1_q), 32'(last_m1));

    $display("[TB] start and abort together");
    if4.m1_in = ~last_m1;
    if4.start = 1'b1;
    if4.abort = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    if4.abort = 1'b0;
    check_output("veto_m1", 32'(if4.m1_q), 32'(last_m1));
    check_output("veto_ready", 32'(if4.ready), 32'd1);

    $display("[TB] async reset during second CORR");
    start_partial(W'($urandom) | 23'h1, W'($urandom), 4);
    #3;
    reset = 1'b0;
    #1;
    check_output("async_ready", 32'(if4.ready), 32'd1);
    check_output("async_valid", 32'(if4.valid), 32'd0);
    check_output("async_ctrl", 32'({if4.mode, if4.stage, if4.rem}), 32'(C_IDLE));
    check_output("async_m1", 32'(if4.m1_q), 32'd0);
    check_output("async_m3", 32'(if4.m3), 32'd0);
    check_output("async_r", 32'(if4.r), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("post_reset_ready", 32'(if4.ready), 32'd1);

    $display("[TB] single iteration back-to-back");
    build_trace(I1, tr1);
    tr1.push_back(C_IDLE);
    tr1.push_back(C_IDLE);
    if1.res_ready = 1'b1;
    if1.start = 1'b1;
    e1_m1 = W'($urandom);
    if1.m1_in = e1_m1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      ph = c % tr1.size();
      check_output($sformatf("b2b_ctrl_%0d", c), 32'({if1.mode, if1.stage, if1.rem}), 32'(tr1[ph]));
      check_output($sformatf("b2b_valid_%0d", c), 32'(if1.valid), 32'(ph == 2 * I1 + 2));
      check_output($sformatf("b2b_ready_%0d", c), 32'(if1.ready), 32'(ph == 2 * I1 + 3));
      if (ph == 0) check_output("b2b_m1", 32'(if1.m1_q), 32'(e1_m1));
      if (ph == 2 * I1 + 2) check_output("b2b_m3", 32'(if1.m3), 32'(e1_m3));
      if1.div_m3  = W'($urandom);
      if1.div_r   = W'($urandom);
      if1.div_dec = 1'($urandom);
      if (ph == 2 * I1 + 1) e1_m3 = if1.div_m3;
      if (ph == 2 * I1 + 3) begin
        e1_m1 = W'($urandom);
        if1.m1_in = e1_m1;
      end
    end
    if1.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
